bool_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 3-input Boolean-theorem logic block (inputs A,B,C; outputs F1,F2,F3).
//  On start, it drives all 8 ABC vectors in order into the external combinational block.

---
 rtl/bool_sweep_ctrl.sv | 119 +++++++++++
 tb/tb_bool_sweep_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bool_sweep_ctrl.sv
// bool_sweep_ctrl: drives all 8 ABC vectors into a 3-input Boolean block and checks
// the returned {F3,F2,F1} against F1=~(A&B)|C, F2=~(A&B)&~C, F3=A.
module bool_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] f_in,
   output logic [2:0] abc_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_map,
   output logic [3:0] err_count
);
   localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int CW = (SC > 1) ? $clog2(SC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, REPORT} state_t;

   state_t          r_state;
   logic [2:0]      r_idx;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_abc;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [7:0]      r_fail_map;
   logic [3:0]      r_err;

   logic            w_nand;
   logic [2:0]      w_gold;
   logic            w_miss;
   logic [3:0]      w_err_next;

   assign w_nand     = ~(r_idx[2] & r_idx[1]);
   assign w_gold     = {r_idx[2], w_nand & ~r_idx[0], w_nand | r_idx[0]};
   assign w_miss     = f_in != w_gold;
   assign w_err_next = (w_miss && r_err != 4'd8) ? r_err + 4'd1 : r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= 3'd0;
         r_cnt      <= '0;
         r_abc      <= 3'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail_map <= 8'h00;
         r_err      <= 4'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start && !abort) begin
                  r_state    <= DRIVE;
                  r_idx      <= 3'd0;
                  r_cnt      <= '0;
                  r_abc      <= 3'd0;
                  r_busy     <= 1'b1;
                  r_pass     <= 1'b0;
                  r_fail_map <= 8'h00;
                  r_err      <= 4'd0;
               end
            end
            DRIVE: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_abc   <= 3'd0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= SAMPLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_abc   <= 3'd0;
               end else begin
                  // f_in is only ever looked at here, so X elsewhere cannot leak into results
                  if (w_miss) r_fail_map[r_idx] <= 1'b1;
                  r_err <= w_err_next;
                  if (r_idx == 3'd7) begin
                     r_state <= REPORT;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_abc   <= 3'd0;
                     r_pass  <= w_err_next == 4'd0;
                  end else begin
                     r_state <= DRIVE;
                     r_idx   <= r_idx + 3'd1;
                     r_abc   <= r_idx + 3'd1;
                  end
               end
            end
            REPORT: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign abc_out   = r_abc;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail_map  = r_fail_map;
   assign err_count = r_err;
endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// tb_bool_sweep_ctrl: directed checks of bool_sweep_ctrl against behavioural models of the
// logic block (correct, F3 stuck-0, F1 forced-1, 2-cycle delayed) with SETTLE_CYCLES 1 and 3.
module tb_bool_sweep_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       start1, abort1, start3, abort3;
   logic [2:0] f1, f3, abc1, abc3;
   logic       busy1, done1, pass1, busy3, done3, pass3;
   logic [7:0] map1, map3;
   logic [3:0] err1, err3;
   logic [1:0] mode;
   logic [2:0] p1a, p1b, p3a, p3b;
   int         total = 0;
   int         bad = 0;

   logic [2:0] gtab [0:7] = '{3'b011, 3'b001, 3'b011, 3'b001, 3'b111, 3'b101, 3'b100, 3'b101};

   always #5 clk = ~clk;

   bool_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f_in(f1), .abc_out(abc1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_map(map1), .err_count(err1));

   bool_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .f_in(f3), .abc_out(abc3),
      .busy(busy3), .done(done3), .pass(pass3), .fail_map(map3), .err_count(err3));

   // mode 0 correct, 1 F3 stuck at 0, 2 F1 forced to 1, 3 output delayed two cycles
   function automatic logic [2:0] blk(input logic [1:0] m, input logic [2:0] v);
      logic [2:0] g;
      g = gtab[v];
      if (m == 2'd1) g[2] = 1'b0;
      if (m == 2'd2) g[0] = 1'b1;
      return g;
   endfunction

   always @(posedge clk) begin
      p1a <= blk(2'd0, abc1);
      p1b <= p1a;
      p3a <= blk(2'd0, abc3);
      p3b <= p3a;
   end

   assign f1 = (mode == 2'd3) ? p1b : blk(mode, abc1);
   assign f3 = p3b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sweep(input logic [1:0] m, input int poke, input logic [7:0] emap,
                        input logic [3:0] eerr, input logic epass, input string tag);
      int n;
      mode = m;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      n = 1;
      chk({tag, "_busy"}, 32'(busy1), 32'd1);
      chk({tag, "_clr"}, {23'd0, pass1, map1}, 32'd0);
      while (!done1 && n < 40) begin
         if (n <= 16 && n[0]) chk({tag, "_abc"}, 32'(abc1), 32'((n - 1) / 2));
         start1 = (n == poke);
         @(negedge clk);
         n++;
      end
      start1 = 1'b0;
      chk({tag, "_done_cyc"}, 32'(n), 32'd17);
      chk({tag, "_busy_rep"}, 32'(busy1), 32'd0);
      chk({tag, "_pass"}, 32'(pass1), 32'(epass));
      chk({tag, "_map"}, 32'(map1), 32'(emap));
      chk({tag, "_err"}, 32'(err1), 32'(eerr));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done1), 32'd0);
      chk({tag, "_hold"}, {19'd0, pass1, map1, err1}, {19'd0, epass, emap, eerr});
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1'b1;
      {start1, abort1, start3, abort3} = '0;
      mode = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_dut1", {15'd0, abc1, busy1, done1, pass1, map1, err1}, 32'd0);
      chk("rst_dut3", {15'd0, abc3, busy3, done3, pass3, map3, err3}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      sweep(2'd0, 0, 8'h00, 4'd0, 1'b1, "t1_good");
      sweep(2'd1, 0, 8'hF0, 4'd4, 1'b0, "t2_f3s0");
      sweep(2'd2, 0, 8'h40, 4'd1, 1'b0, "t3_f1s1");
      sweep(2'd0, 0, 8'h00, 4'd0, 1'b1, "t3_rerun");

      @(negedge clk) start3 = 1'b1;
      @(negedge clk) start3 = 1'b0;
      n = 1;
      while (!done3 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("t4_s3_done_cyc", 32'(n), 32'd33);
      chk("t4_s3_result", {19'd0, pass3, map3, err3}, {19'd0, 1'b1, 8'h00, 4'd0});
      sweep(2'd3, 0, 8'hFE, 4'd7, 1'b0, "t4_s1_delay");

      mode = 2'd3;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_abc_i3", 32'(abc1), 32'd3);
      abort1 = 1'b1;
      @(negedge clk) abort1 = 1'b0;
      chk("t5_abort_busy", 32'(busy1), 32'd0);
      chk("t5_abort_abc", 32'(abc1), 32'd0);
      chk("t5_abort_partial", {19'd0, pass1, map1, err1}, {19'd0, 1'b0, 8'h06, 4'd2});
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done1 || busy1) seen = 1'b1;
      end
      chk("t5_no_done", 32'(seen), 32'd0);
      start1 = 1'b1;
      abort1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      abort1 = 1'b0;
      chk("t5_start_abort_busy", 32'(busy1), 32'd0);
      chk("t5_start_abort_keep", {20'd0, map1, err1}, {20'd0, 8'h06, 4'd2});
      sweep(2'd0, 5, 8'h00, 4'd0, 1'b1, "t5_poke");

      mode = 2'd1;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      repeat (10) @(negedge clk);
      chk("t6_abc_i5", 32'(abc1), 32'd5);
      chk("t6_partial", {20'd0, map1, err1}, {20'd0, 8'h10, 4'd1});
      #1 rst = 1'b1;
      #1 chk("t6_async_rst", {15'd0, abc1, busy1, done1, pass1, map1, err1}, 32'd0);
      @(negedge clk) rst = 1'b0;
      chk("t6_after_rst", {15'd0, abc1, busy1, done1, pass1, map1, err1}, 32'd0);
      sweep(2'd0, 0, 8'h00, 4'd0, 1'b1, "t6_good");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
